// File: rtl/ahb_apb_bridge.sv
// AHB-Lite slave to APB4 master bridge: one AHB transfer becomes one APB setup/access
// sequence, with wait-state stretching, slave-error mapping and an access watchdog.
module ahb_apb_bridge #(
  parameter int unsigned HADDR_SIZE = 32,
  parameter int unsigned PADDR_SIZE = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  CLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [31:0]           HRDATA,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [PADDR_SIZE-1:0] PADDR,
  output logic [31:0]           PWDATA,
  output logic [3:0]            PSTRB,
  input  logic                  PREADY,
  input  logic                  PSLVERR,
  input  logic [31:0]           PRDATA
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) + 1 : 1;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSetup,
    StAccess,
    StDone,
    StErr1,
    StErr2
  } state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [PADDR_SIZE-1:0] paddr_q;
  logic [1:0]            lsb_q;
  logic [1:0]            hsize_q;
  logic                  pwrite_q;
  logic [31:0]           pwdata_q;
  logic [3:0]            pstrb_q;
  logic [31:0]           hrdata_q;
  logic                  hreadyout_q, hresp_q, psel_q, penable_q;

  logic                  valid, illegal, capture, rd_done, timeout_hit;
  logic [3:0]            strb_load;

  assign valid   = HSEL & HREADY & HTRANS[1];
  assign illegal = (HSIZE > 3'd2) ||
                   ((HSIZE == 3'd1) && HADDR[0]) ||
                   ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CntW'(TIMEOUT - 1));
  assign rd_done     = (state_q == StAccess) && PREADY && !PSLVERR && !pwrite_q;

  always_comb begin
    strb_load = 4'b1111;
    case (hsize_q)
      2'd0:    strb_load = 4'b0001 << lsb_q;
      2'd1:    strb_load = lsb_q[1] ? 4'b1100 : 4'b0011;
      default: strb_load = 4'b1111;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (valid) begin
          capture = !illegal;
          state_d = illegal ? StErr1 : StLoad;
        end
      end
      StLoad: begin
        cnt_d   = '0;
        state_d = StSetup;
      end
      StSetup: state_d = StAccess;
      StAccess: begin
        cnt_d = cnt_q + CntW'(1);
        if (PREADY) begin
          state_d = PSLVERR ? StErr1 : StDone;
        end else if (timeout_hit) begin
          state_d = StErr1;
        end
      end
      StErr1:  state_d = StErr2;
      StErr2:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Bus outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge CLK) begin
    if (!HRESETn) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      paddr_q     <= '0;
      lsb_q       <= '0;
      hsize_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      hrdata_q    <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hreadyout_q <= (state_d == StIdle) || (state_d == StDone) || (state_d == StErr2);
      hresp_q     <= (state_d == StErr1) || (state_d == StErr2);
      psel_q      <= (state_d == StSetup) || (state_d == StAccess);
      penable_q   <= (state_d == StAccess);
      if (capture) begin
        paddr_q  <= HADDR[PADDR_SIZE+1:2];
        lsb_q    <= HADDR[1:0];
        hsize_q  <= HSIZE[1:0];
        pwrite_q <= HWRITE;
      end
      if (state_q == StLoad) begin
        pwdata_q <= pwrite_q ? HWDATA : 32'h0;
        pstrb_q  <= pwrite_q ? strb_load : 4'b0000;
      end
      if (rd_done) begin
        hrdata_q <= PRDATA;
      end
    end
  end

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
  assign HRDATA    = hrdata_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign PSTRB     = pstrb_q;

  logic unused_ok;
  assign unused_ok = ^{HADDR[HADDR_SIZE-1:PADDR_SIZE+2], HTRANS[0]};

endmodule

// File: doc/ahb_apb_bridge.md
# ahb_apb_bridge

AHB-Lite slave to APB4 master bridge that drives the APB port of the GPIO block (PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB in; PREADY, PRDATA, PSLVERR out). It converts one AHB transfer at a time into a single APB setup/access sequence. It stretches the AHB data phase with HREADYOUT and maps APB slave errors and access timeouts onto the two-cycle AHB ERROR response.

## Interface
- HADDR_SIZE, 32, AHB address width
- PADDR_SIZE, 4, APB word-address width (GPIO register index)
- TIMEOUT, 16, maximum ACCESS cycles without PREADY before an error; 0 disables the timeout
- CLK  in  1  single clock for AHB and APB sides
- HRESETn  in  1  reset, synchronous, active-low
- HSEL  in  1  bridge selected
- HADDR  in  HADDR_SIZE  byte address
- HTRANS  in  2  transfer type; bit 1 set = NONSEQ/SEQ
- HWRITE  in  1  1 = write
- HSIZE  in  3  0 = byte, 1 = half, 2 = word
- HWDATA  in  32  write data, valid in the data phase
- HREADY  in  1  bus-level ready
- HREADYOUT  out  1  data-phase ready
- HRESP  out  1  1 = ERROR
- HRDATA  out  32  read data
- PSEL, PENABLE, PWRITE  out  1  APB control
- PADDR  out  PADDR_SIZE  equals HADDR[PADDR_SIZE+1:2]
- PWDATA  out  32  write data
- PSTRB  out  4  byte strobes
- PREADY, PSLVERR  in  1  APB response
- PRDATA  in  32  APB read data

## Operation
- Valid transfer is HSEL & HREADY & HTRANS[1], sampled only in IDLE or DONE. The bridge registers HADDR, HWRITE and HSIZE.
- Illegal transfers produce ERR1→ERR2 with no APB access:
  - HSIZE > 2
  - half with HADDR[0] = 1
  - word with HADDR[1:0] ≠ 0
- FSM states: IDLE, LOAD, SETUP, ACCESS, DONE, ERR1, ERR2.
- IDLE:
  - HREADYOUT = 1, HRESP = 0, PSEL = PENABLE = 0.
  - A legal valid transfer moves to LOAD.
  - An illegal valid transfer moves to ERR1.
- LOAD:
  - HREADYOUT = 0.
  - Latches HWDATA into PWDATA for writes; PWDATA = 0 for reads.
  - Computes PSTRB for writes:
    - byte: 1 << HADDR[1:0]
    - half: 0011 << (2·HADDR[1])
    - word: 1111
  - PSTRB = 0000 for reads.
  - Moves to SETUP.
- SETUP: PSEL = 1, PENABLE = 0, HREADYOUT = 0. Moves to ACCESS.
- ACCESS:
  - PSEL = PENABLE = 1, HREADYOUT = 0. The watchdog counter increments each cycle.
  - PREADY & !PSLVERR → DONE; HRDATA is latched from PRDATA on reads.
  - PREADY & PSLVERR → ERR1.
  - Counter reaching TIMEOUT without PREADY → ERR1, with PSEL/PENABLE dropped.
- DONE:
  - HREADYOUT = 1, HRESP = 0, PSEL = PENABLE = 0.
  - A valid transfer moves to LOAD (back-to-back) or ERR1 (illegal); otherwise → IDLE.
- ERR1: HREADYOUT = 0, HRESP = 1. Moves to ERR2.
- ERR2: HREADYOUT = 1, HRESP = 1. Moves to IDLE; transfers presented in ERR2 are ignored.
- HRDATA holds its last value until the next completed read.
- The watchdog counter clears on entry to SETUP.
- Address, data and strobe registers hold steady from SETUP through the end of ACCESS.

## Timing
- Reset (HRESETn low at a rising edge): next cycle is IDLE with:
  - HREADYOUT = 1, HRESP = 0
  - PSEL = PENABLE = PWRITE = 0
  - PADDR = PWDATA = HRDATA = 0, PSTRB = 0
  - counter = 0
- Reset mid-ACCESS aborts the APB cycle immediately; no completion is reported.
- Zero-wait-state APB slave, address phase in cycle T0:
  - T1 LOAD
  - T2 SETUP
  - T3 ACCESS
  - T4 DONE (HREADYOUT = 1, HRDATA valid)
- Each APB wait state adds one ACCESS cycle.
- Error path: PSLVERR sampled in cycle Tn gives ERR1 at Tn+1 and ERR2 at Tn+2.
- Timeout: PSEL drops after TIMEOUT ACCESS cycles; ERR1 follows.
- All outputs are registered, and all inputs are sampled only at rising CLK edges.

## Test plan
- Write to HADDR 0x08, HSIZE 2, data 0xA5A5_1234, PREADY = 1:
  - PADDR = 2, PWRITE = 1, PWDATA = 0xA5A5_1234, PSTRB = 1111.
  - PSEL rises at T2, PENABLE at T3, HREADYOUT = 1 at T4.
- Byte write to HADDR 0x0D, data 0x0000_7700 → PADDR = 3, PSTRB = 0010. Half write to HADDR 0x06 → PSTRB = 1100.
- Read from HADDR 0x0C, PREADY delayed 2 cycles, PRDATA = 0xDEAD_BEEF → PENABLE high for 3 cycles, PSTRB = 0000, HRDATA = 0xDEAD_BEEF with HREADYOUT = 1.
- Write with PSLVERR = 1 on PREADY → HRESP = 1 for two cycles, with HREADYOUT 0 then 1. The next transfer completes normally.
- PREADY held at 0:
  - With TIMEOUT = 16: exactly 16 ACCESS cycles, then ERR1/ERR2.
  - Misaligned word at HADDR 0x02: ERR1/ERR2 with no PSEL assertion.
- Back-to-back write then read presented in DONE → second LOAD directly after DONE with no IDLE cycle. HRESETn low during ACCESS → IDLE with all outputs at reset values on the next cycle.
